// File: rtl/led_channel_conditioner.sv
// Per-channel input conditioning: synchronise, debounce, then select raw, debounced,
// stretched or toggled level onto a wide registered output, plus a rising-edge strobe.
module led_channel_conditioner #(
    parameter int NUM_CHANNELS    = 4,
    parameter int OUTPUT_WIDTH    = 23,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STRETCH_CYCLES  = 8
) (
    input  logic                    ext_clk,
    input  logic                    ext_rst,
    input  logic [NUM_CHANNELS-1:0] led_in,
    input  logic [1:0]              mode,
    output logic [OUTPUT_WIDTH-1:0] dummy_output,
    output logic [NUM_CHANNELS-1:0] rise_strobe
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int STR_W = $clog2(STRETCH_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH_CYCLES);

    logic [NUM_CHANNELS-1:0] sync_r [SYNC_STAGES];
    logic [NUM_CHANNELS-1:0] sync_s;
    logic [NUM_CHANNELS-1:0] deb_r;
    logic [NUM_CHANNELS-1:0] deb_nxt_s;
    logic [NUM_CHANNELS-1:0] rise_s;
    logic [NUM_CHANNELS-1:0] rise_r;
    logic [NUM_CHANNELS-1:0] tog_r;
    logic [NUM_CHANNELS-1:0] stretch_on_s;
    logic [NUM_CHANNELS-1:0] out_sel_s;
    logic [CNT_W-1:0]        cnt_r     [NUM_CHANNELS];
    logic [CNT_W-1:0]        cnt_nxt_s [NUM_CHANNELS];
    logic [STR_W-1:0]        str_r     [NUM_CHANNELS];
    logic [STR_W-1:0]        str_nxt_s [NUM_CHANNELS];

    // Synchroniser shift chain for the asynchronous inputs
    always_ff @(posedge ext_clk) begin
        if (ext_rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= '0;
            end
        end else begin
            sync_r[0] <= led_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Debounce next state: accept a new level only after it has held long enough
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            deb_nxt_s[i] = deb_r[i];
            cnt_nxt_s[i] = '0;
            if (sync_s[i] != deb_r[i]) begin
                if (cnt_r[i] == DEB_LAST) begin
                    deb_nxt_s[i] = sync_s[i];
                    cnt_nxt_s[i] = '0;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
                end
            end else begin
                cnt_nxt_s[i] = '0;
            end
        end
    end

    // Rise is taken from the next-state so stretch/toggle update on the accepting edge
    assign rise_s = deb_nxt_s & ~deb_r;

    // Stretch counter next state: reload on every rise, otherwise count down to zero
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            stretch_on_s[i] = (str_r[i] != '0);
            if (rise_s[i]) begin
                str_nxt_s[i] = STR_LOAD;
            end else if (str_r[i] != '0) begin
                str_nxt_s[i] = str_r[i] - STR_W'(1);
            end else begin
                str_nxt_s[i] = str_r[i];
            end
        end
    end

    // Output mode select; only the mux depends on mode, all state runs continuously
    always_comb begin
        case (mode)
            2'd0:    out_sel_s = sync_s;
            2'd1:    out_sel_s = deb_r;
            2'd2:    out_sel_s = stretch_on_s;
            2'd3:    out_sel_s = tog_r;
            default: out_sel_s = '0;
        endcase
    end

    // Channel state and registered outputs
    always_ff @(posedge ext_clk) begin
        if (ext_rst) begin
            deb_r        <= '0;
            rise_r       <= '0;
            tog_r        <= '0;
            rise_strobe  <= '0;
            dummy_output <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                cnt_r[i] <= '0;
                str_r[i] <= '0;
            end
        end else begin
            deb_r        <= deb_nxt_s;
            rise_r       <= rise_s;
            tog_r        <= tog_r ^ rise_s;
            // Delayed one stage so the strobe lines up with the debounced output
            rise_strobe  <= rise_r;
            dummy_output <= OUTPUT_WIDTH'(out_sel_s);
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
                str_r[i] <= str_nxt_s[i];
            end
        end
    end

endmodule

// File: tb/tb_led_channel_conditioner.sv
// Scoreboard bench for led_channel_conditioner: expected outputs are queued per edge
// from the documented latencies and compared one time unit after each rising edge.
module tb_led_channel_conditioner;

    logic        ext_clk = 1'b0;
    logic        ext_rst;
    logic [3:0]  led_in;
    logic [1:0]  mode;
    logic [22:0] dummy_output;
    logic [3:0]  rise_strobe;
    logic [22:0] dummy_output_fast;
    logic [3:0]  rise_strobe_fast;

    typedef struct packed {
        logic [22:0] out;
        logic [3:0]  strb;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 ext_clk = ~ext_clk;

    led_channel_conditioner dut (
        .ext_clk      (ext_clk),
        .ext_rst      (ext_rst),
        .led_in       (led_in),
        .mode         (mode),
        .dummy_output (dummy_output),
        .rise_strobe  (rise_strobe)
    );

    // Second instance with single-cycle debounce, used for retrigger within a stretch
    led_channel_conditioner #(.DEBOUNCE_CYCLES(1)) dut_fast (
        .ext_clk      (ext_clk),
        .ext_rst      (ext_rst),
        .led_in       (led_in),
        .mode         (mode),
        .dummy_output (dummy_output_fast),
        .rise_strobe  (rise_strobe_fast)
    );

    task automatic tick();
        @(posedge ext_clk);
        #1;
    endtask

    task automatic push_exp(input logic [22:0] o, input logic [3:0] s);
        exp_t e;
        e.out  = o;
        e.strb = s;
        sb_q.push_back(e);
    endtask

    task automatic apply_reset();
        ext_rst = 1'b1;
        led_in  = 4'b0000;
        repeat (3) tick();
        ext_rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int j = 1; j <= 5; j++) begin
            ext_rst = 1'b1;
            led_in  = 4'b1111;
            mode    = 2'd1;
            push_exp(23'h0, 4'h0);
            tick();
            e = sb_q.pop_front();
            n_checks++;
            if (dummy_output !== e.out) begin
                n_fail++;
                $display("FAIL reset_hold edge %0d: dummy_output=%h required %h", j, dummy_output, e.out);
            end
            n_checks++;
            if (rise_strobe !== e.strb) begin
                n_fail++;
                $display("FAIL reset_hold_strobe edge %0d: rise_strobe=%h required %h", j, rise_strobe, e.strb);
            end
        end
        ext_rst = 1'b0;
        for (int j = 1; j <= 22; j++) begin
            push_exp((j >= 19) ? 23'h00000F : 23'h0, (j == 19) ? 4'hF : 4'h0);
            tick();
            e = sb_q.pop_front();
            n_checks++;
            if (dummy_output !== e.out) begin
                n_fail++;
                $display("FAIL reset_release edge %0d: dummy_output=%h required %h", j, dummy_output, e.out);
            end
            n_checks++;
            if (rise_strobe !== e.strb) begin
                n_fail++;
                $display("FAIL reset_release_strobe edge %0d: rise_strobe=%h required %h", j, rise_strobe, e.strb);
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        apply_reset();
        mode = 2'd1;
        for (int j = 1; j <= 40; j++) begin
            led_in = (j <= 15) ? 4'b0001 : 4'b0000;
            push_exp(23'h0, 4'h0);
            tick();
            e = sb_q.pop_front();
            n_checks++;
            if (dummy_output !== e.out || rise_strobe !== e.strb) begin
                n_fail++;
                $display("FAIL glitch15 edge %0d: out=%h strobe=%h required out=%h strobe=%h",
                         j, dummy_output, rise_strobe, e.out, e.strb);
            end
        end
        apply_reset();
        for (int j = 1; j <= 40; j++) begin
            led_in = (j <= 16) ? 4'b0001 : 4'b0000;
            push_exp((j >= 19 && j <= 34) ? 23'h1 : 23'h0, (j == 19) ? 4'h1 : 4'h0);
            tick();
            e = sb_q.pop_front();
            n_checks++;
            if (dummy_output !== e.out || rise_strobe !== e.strb) begin
                n_fail++;
                $display("FAIL pulse16 edge %0d: out=%h strobe=%h required out=%h strobe=%h",
                         j, dummy_output, rise_strobe, e.out, e.strb);
            end
        end
    endtask

    task automatic test_stretch();
        exp_t e;
        apply_reset();
        mode = 2'd2;
        for (int j = 1; j <= 30; j++) begin
            led_in = 4'b0010;
            push_exp((j >= 19 && j <= 26) ? 23'h2 : 23'h0, (j == 19) ? 4'h2 : 4'h0);
            tick();
            e = sb_q.pop_front();
            n_checks++;
            if (dummy_output !== e.out || rise_strobe !== e.strb) begin
                n_fail++;
                $display("FAIL stretch edge %0d: out=%h strobe=%h required out=%h strobe=%h",
                         j, dummy_output, rise_strobe, e.out, e.strb);
            end
        end
    endtask

    task automatic test_retrigger();
        exp_t e;
        apply_reset();
        mode = 2'd2;
        for (int j = 1; j <= 20; j++) begin
            led_in = (j <= 2 || j >= 5) ? 4'b0010 : 4'b0000;
            push_exp((j >= 4 && j <= 15) ? 23'h2 : 23'h0, (j == 4 || j == 8) ? 4'h2 : 4'h0);
            tick();
            e = sb_q.pop_front();
            n_checks++;
            if (dummy_output_fast !== e.out || rise_strobe_fast !== e.strb) begin
                n_fail++;
                $display("FAIL retrigger edge %0d: out=%h strobe=%h required out=%h strobe=%h",
                         j, dummy_output_fast, rise_strobe_fast, e.out, e.strb);
            end
        end
    endtask

    task automatic test_toggle();
        exp_t e;
        int   flips;
        apply_reset();
        mode = 2'd3;
        for (int j = 1; j <= 120; j++) begin
            led_in = (((j - 1) % 40) < 20) ? 4'b0100 : 4'b0000;
            flips  = ((j >= 19) ? 1 : 0) + ((j >= 59) ? 1 : 0) + ((j >= 99) ? 1 : 0);
            push_exp(((flips % 2) == 1) ? 23'h4 : 23'h0,
                     (j == 19 || j == 59 || j == 99) ? 4'h4 : 4'h0);
            tick();
            e = sb_q.pop_front();
            n_checks++;
            if (dummy_output !== e.out || rise_strobe !== e.strb) begin
                n_fail++;
                $display("FAIL toggle edge %0d: out=%h strobe=%h required out=%h strobe=%h",
                         j, dummy_output, rise_strobe, e.out, e.strb);
            end
        end
    endtask

    task automatic test_mode_switch();
        exp_t e;
        apply_reset();
        for (int j = 1; j <= 55; j++) begin
            led_in = (j <= 20) ? 4'b1000 : 4'b0000;
            mode   = (j >= 46 && j <= 50) ? 2'd0 : 2'd3;
            push_exp((j >= 19 && (j <= 45 || j >= 51)) ? 23'h8 : 23'h0, (j == 19) ? 4'h8 : 4'h0);
            tick();
            e = sb_q.pop_front();
            n_checks++;
            if (dummy_output !== e.out || rise_strobe !== e.strb) begin
                n_fail++;
                $display("FAIL mode_switch edge %0d: out=%h strobe=%h required out=%h strobe=%h",
                         j, dummy_output, rise_strobe, e.out, e.strb);
            end
        end
    endtask

    task automatic test_reset_mid_stretch();
        exp_t e;
        apply_reset();
        mode = 2'd2;
        for (int j = 1; j <= 50; j++) begin
            ext_rst = (j == 22 || j == 23) ? 1'b1 : 1'b0;
            led_in  = (j <= 21) ? 4'b0001 : 4'b0000;
            push_exp((j >= 19 && j <= 21) ? 23'h1 : 23'h0, (j == 19) ? 4'h1 : 4'h0);
            tick();
            e = sb_q.pop_front();
            n_checks++;
            if (dummy_output !== e.out || rise_strobe !== e.strb) begin
                n_fail++;
                $display("FAIL reset_mid_stretch edge %0d: out=%h strobe=%h required out=%h strobe=%h",
                         j, dummy_output, rise_strobe, e.out, e.strb);
            end
        end
        ext_rst = 1'b0;
    endtask

    initial begin
        ext_rst = 1'b1;
        led_in  = 4'b1111;
        mode    = 2'd1;
        test_reset();
        test_glitch();
        test_stretch();
        test_retrigger();
        test_toggle();
        test_mode_switch();
        test_reset_mid_stretch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
